// File: rtl/otp_pingpong_xor.sv
// rtl/otp_pingpong_xor.sv - two-bank one-time-pad store that XORs streamed raw words with the pad.
// Optional DRAIN_ABORT_EN adds iabort to discard the bank being drained.
module otp_pingpong_xor #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 10
) (
    input  logic              iclk,
    input  logic              irst,
    output logic              okey_start,
    input  logic              ikey_valid,
    input  logic [DATA_W-1:0] ikey_data,
    output logic              okey_ready,
    output logic              oblk_ready,
    input  logic              istart_blk,
    input  logic              iraw_valid,
    input  logic [DATA_W-1:0] iraw_data,
`ifdef DRAIN_ABORT_EN
    input  logic              iabort,
`endif
    output logic              ores_valid,
    output logic [DATA_W-1:0] ores_data,
    output logic              oblk_done,
    output logic              oerr
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t       state [2];
    logic              wsel;
    logic              rsel;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic              req;
    logic [DATA_W-1:0] mem [2*DEPTH];
    logic [DATA_W-1:0] pad_q;
    logic [DATA_W-1:0] raw_q;
    logic              res_valid_q;
    logic              done_q;
    logic              err_q;

    logic key_fire;
    logic draining;
    logic abort;
    logic raw_fire;
    logic claim;
    logic want_start;

    assign okey_ready = (state[wsel] == EMPTY) || (state[wsel] == FILLING);
    assign oblk_ready = (state[rsel] == FULL);
    assign draining   = (state[rsel] == DRAINING);
    assign key_fire   = !irst && ikey_valid && okey_ready;
    assign claim      = istart_blk && oblk_ready;

`ifdef DRAIN_ABORT_EN
    assign abort = iabort && draining;
`else
    assign abort = 1'b0;
`endif

    // A word presented alongside an abort is swallowed, not flagged as an underrun.
    assign raw_fire   = !irst && iraw_valid && draining && !abort;
    // A word arriving unrequested still consumes the request slot for this bank.
    assign want_start = (state[wsel] == EMPTY) && !req && !key_fire;

    assign ores_valid = res_valid_q;
    assign ores_data  = res_valid_q ? (raw_q ^ pad_q) : '0;
    assign oblk_done  = done_q;
    assign oerr       = err_q;

    always_ff @(posedge iclk) begin
        if (irst) begin
            state[0]    <= EMPTY;
            state[1]    <= EMPTY;
            wsel        <= 1'b0;
            rsel        <= 1'b0;
            waddr       <= '0;
            raddr       <= '0;
            req         <= 1'b0;
            okey_start  <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            okey_start  <= want_start;
            res_valid_q <= raw_fire;
            done_q      <= raw_fire && (&raddr);
            if (want_start)
                req <= 1'b1;
            if (iraw_valid && !draining)
                err_q <= 1'b1;

            if (key_fire) begin
                req   <= 1'b0;
                waddr <= waddr + 1'b1;
                if (&waddr) begin
                    state[wsel] <= FULL;
                    wsel        <= ~wsel;
                end else begin
                    state[wsel] <= FILLING;
                end
            end

            // Fill and drain touch different banks, so both may complete in one cycle.
            if (claim) begin
                state[rsel] <= DRAINING;
                raddr       <= '0;
            end else if (abort || (raw_fire && (&raddr))) begin
                state[rsel] <= EMPTY;
                rsel        <= ~rsel;
                raddr       <= '0;
            end else if (raw_fire) begin
                raddr <= raddr + 1'b1;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (key_fire)
            mem[{wsel, waddr}] <= ikey_data;
        if (raw_fire) begin
            pad_q <= mem[{rsel, raddr}];
            raw_q <= iraw_data;
        end
    end
endmodule

// File: doc/otp_pingpong_xor.md
Name: otp_pingpong_xor

Overview:
Parametrised successor to the single-bank OTP/raw XOR path of the GhostSD top level.
- Double-buffers one-time-pad keystream in two banks: the OTP generator fills one bank while the SD engine streams raw data through the other and receives data XORed with the pad.
- Removes the stall between consecutive SD blocks.
- Runs entirely in the iclk domain.

Parameters:
DATA_W, 4, width of one keystream/data word (4 = one SD D[3:0] nibble)
ADDR_W, 10, log2 of words per block; DEPTH = 2**ADDR_W words per bank

Ports:
iclk  in  1  system clock
irst  in  1  reset, synchronous, active-high
okey_start  out  1  one-cycle pulse: generator should begin producing the next block
ikey_valid  in  1  keystream word valid
ikey_data  in  DATA_W  keystream word
okey_ready  out  1  module can accept a keystream word this cycle
oblk_ready  out  1  a full pad bank is available to the consumer
istart_blk  in  1  consumer claims the ready bank (pulse)
iraw_valid  in  1  raw data word valid
iraw_data  in  DATA_W  raw data word
ores_valid  out  1  result word valid
ores_data  out  DATA_W  iraw_data XOR pad word
oblk_done  out  1  pulse coincident with the last ores_valid of a block
oerr  out  1  sticky: raw word presented while no bank is draining

Behaviour:
- Only one clock and one reset exist: iclk, with irst synchronous and active-high.
- Storage: 2 banks x DEPTH x DATA_W, synchronous-read RAM. Each bank has state EMPTY, FILLING, FULL or DRAINING.
- Pointers: wsel/waddr (producer), rsel/raddr (consumer).
- Reset (irst=1 at an iclk edge), including mid-operation:
  - Both banks go EMPTY.
  - wsel=rsel=0, waddr=raddr=0.
  - All outputs 0 except okey_ready, which is 1 from the first cycle after reset.
  - oerr is cleared and any in-flight result is discarded.
- okey_start:
  - Pulses once when bank[wsel] is EMPTY and no request is outstanding. The first pulse comes the cycle after irst deasserts.
  - The request is cleared when the first word of that bank is accepted.
  - It is never re-pulsed while the bank is FILLING.
- Producer side:
  - okey_ready = (bank[wsel] is EMPTY or FILLING).
  - Each accepted word (ikey_valid && okey_ready) is written at mem[wsel][waddr]; waddr increments; EMPTY becomes FILLING.
  - When waddr = DEPTH-1 is accepted: bank becomes FULL, wsel toggles, waddr=0.
  - ikey_valid while okey_ready=0 is ignored; no data is lost from stored banks.
- oblk_ready = (bank[rsel] is FULL), evaluated as a registered-state combinational decode.
- Consumer claim:
  - istart_blk with oblk_ready=1: bank becomes DRAINING, raddr=0, oblk_ready drops next cycle.
  - istart_blk with oblk_ready=0, or while already DRAINING: ignored, no error.
- Drain path:
  - While bank[rsel] is DRAINING, each iraw_valid reads mem[rsel][raddr] and increments raddr.
  - ores_valid/ores_data appear exactly 1 cycle later, with ores_data = registered iraw_data XOR pad word.
  - Back-to-back valids give back-to-back results. Gaps in iraw_valid are allowed.
- Drain completion:
  - On the word with raddr = DEPTH-1: bank becomes EMPTY, rsel toggles, raddr=0.
  - oblk_done pulses with that word's ores_valid, one cycle later.
- iraw_valid while no bank is DRAINING: word is dropped, no ores_valid, oerr set. oerr stays set until reset.
- Simultaneous events:
  - Fill-complete of one bank and drain-complete of the other in the same cycle: both transitions apply.
  - If the drained bank becomes the new bank[wsel], okey_start pulses the following cycle.
- Pad isolation: a bank is never written while DRAINING or FULL, and never read while FILLING.

Optional Feature:
- Macro: DRAIN_ABORT_EN.
- Defined:
  - Adds input port iabort (1 bit).
  - iabort=1 while bank[rsel] is DRAINING: bank becomes EMPTY, rsel toggles, raddr=0.
  - Any word presented that same cycle is dropped, with no ores_valid and no oblk_done.
  - A result already in flight from the previous cycle is still emitted.
  - iabort at any other time is ignored.
- Undefined: no iabort port; a claimed bank must be drained fully.

Test Plan:
- Case 1, depth and ordering (ADDR_W=2, DATA_W=4):
  - Stimulus: reset, then feed keys 1,2,3,4; assert istart_blk; stream raw F,F,F,F.
  - Expected: okey_start pulses once after reset; oblk_ready=1 after the 4th key; ores_data = E,D,C,B with 1-cycle latency; oblk_done with the 4th result.
- Case 2, ping-pong:
  - Stimulus: fill bank0; while draining it, feed 4 more keys.
  - Expected: bank1 becomes FULL during the drain; okey_ready=0 after 8 keys until bank0 drains; okey_start pulses the cycle after bank0 empties.
- Case 3, underrun:
  - Stimulus: iraw_valid=1 with data 5 before any istart_blk.
  - Expected: no ores_valid; oerr=1 and stays 1 until irst.
- Case 4, gapped drain:
  - Stimulus: raw words on cycles 0, 2, 3, 7.
  - Expected: results on cycles 1, 3, 4, 8; oblk_done on cycle 8 only.
- Case 5, reset mid-operation:
  - Stimulus: irst asserted mid-fill and mid-drain.
  - Expected: next cycle oblk_ready=0, ores_valid=0, oerr=0, okey_ready=1; okey_start pulses once after release.
- Case 6 (DRAIN_ABORT_EN):
  - Stimulus: iabort after 2 of 4 drained words.
  - Expected: no oblk_done; the other bank (if FULL) becomes oblk_ready next cycle; the aborted bank refills from key 0.
